// File: rtl/parallel_cpu_debug_pkg.sv
// Shared constants for the CPU debug OCI memory sequencer: FSM state
// encoding and the bit positions of the fields carried in the 38-bit jdo word.
package parallel_cpu_debug_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_REQ = 2'd1;
    localparam logic [1:0] ST_RD_CAP = 2'd2;
    localparam logic [1:0] ST_WR_REQ = 2'd3;

    // jdo field positions
    localparam int JDO_W        = 38;
    localparam int JDO_RD_NOW   = 35;  // ocimem_a: issue a read after the address load
    localparam int JDO_CLR_ERR  = 36;  // ocimem_a: clear the sticky monitor_error
    localparam int JDO_ADDR_LSB = 17;  // address field base
    localparam int JDO_DATA_LSB = 3;   // write data field base

endpackage : parallel_cpu_debug_pkg

// File: rtl/parallel_cpu_debug_stall_timer.sv
// Counts consecutive cycles a memory request spends stalled and flags expiry
// on the stalled cycle that brings the count to TIMEOUT_CYC. The count
// restarts whenever the stall ends.
module parallel_cpu_debug_stall_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = stall && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Next count: advance while stalled, restart on expiry or when the stall ends
    always_comb begin
        cnt_d = '0;
        if (stall && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : parallel_cpu_debug_stall_timer

// File: rtl/parallel_cpu_debug_ocimem_seq.sv
// Sysclk-domain sequencer turning debug-slave action strobes plus the jdo word
// into single-word read/write transactions on the OCI RAM port, and returning
// read data and status to the JTAG side.
// Optional feature: define OCIMEM_TIMEOUT_EN to abandon a request that stays
// stalled on mem_waitrequest for TIMEOUT_CYC cycles.
module parallel_cpu_debug_ocimem_seq
    import parallel_cpu_debug_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mon_q, mon_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic              any_strobe;
    logic              timeout_hit;
    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_data;
    logic              unused_jdo_bits;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_data   = jdo[JDO_DATA_LSB +: DATA_W];
    assign unused_jdo_bits = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

`ifdef OCIMEM_TIMEOUT_EN
    logic req_stalled;
    assign req_stalled = (read_q | write_q) & mem_waitrequest;

    parallel_cpu_debug_stall_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_stall_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (req_stalled),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic: strobe decode in IDLE, request handshakes elsewhere
    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mon_d   = mon_q;
        read_d  = read_q;
        write_d = write_q;
        ready_d = ready_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                // Fixed priority; losing strobes in the same cycle vanish without error.
                if (take_action_ocimem_a) begin
                    if (jdo[JDO_CLR_ERR]) begin
                        error_d = 1'b0;
                    end
                    addr_d = jdo_addr;
                    if (jdo[JDO_RD_NOW]) begin
                        state_d = ST_RD_REQ;
                        read_d  = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    state_d = ST_WR_REQ;
                    wdata_d = jdo_data;
                    write_d = 1'b1;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD_REQ;
                    read_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            ST_RD_REQ: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    state_d = ST_RD_CAP;
                    read_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    read_d  = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end

            ST_RD_CAP: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
                mon_d   = mem_readdata;
                addr_d  = addr_q + ADDR_W'(1);
                ready_d = 1'b1;
            end

            ST_WR_REQ: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    ready_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State registers; asynchronous reset drops any pending request at once
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            read_q  <= read_d;
            write_q <= write_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign mem_address   = addr_q;
    assign mem_read      = read_q;
    assign mem_write     = write_q;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule : parallel_cpu_debug_ocimem_seq
